// File: rtl/fft_stage_sequencer_pkg.sv
// Shared types and widths for the radix-2 DIT FFT stage sequencer.
// Build option: FFT_STALL_COUNT_EN adds a stall cycle counter to the top.
package fft_pkg;

    localparam int ADDR_W = 11;
    localparam int WORD_W = 64;

    typedef enum logic [3:0] {
        IDLE,
        RD,
        RD_REL,
        BF_ISSUE,
        BF_WAIT,
        WR,
        WR_REL,
        ADV,
        DONE
    } fft_state_e;

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// RAM controller and butterfly unit signals seen by the FFT sequencer.
// master = sequencer side, slave = controller/butterfly side.
interface fft_stage_sequencer_if;
    import fft_pkg::*;

    logic              read_enable;
    logic              write_enable;
    logic [ADDR_W-1:0] a_address;
    logic [ADDR_W-1:0] b_address;
    logic [ADDR_W-1:0] twiddle_address;
    logic [WORD_W-1:0] a_write;
    logic [WORD_W-1:0] b_write;
    logic [WORD_W-1:0] a_read;
    logic [WORD_W-1:0] b_read;
    logic [WORD_W-1:0] twiddle_read;
    logic              ready;

    logic              bf_valid;
    logic [WORD_W-1:0] bf_a;
    logic [WORD_W-1:0] bf_b;
    logic [WORD_W-1:0] bf_w;
    logic              bf_ready;
    logic              bf_done;
    logic [WORD_W-1:0] bf_x;
    logic [WORD_W-1:0] bf_y;

    modport master (
        output read_enable, write_enable,
        output a_address, b_address, twiddle_address,
        output a_write, b_write,
        input  a_read, b_read, twiddle_read, ready,
        output bf_valid, bf_a, bf_b, bf_w,
        input  bf_ready, bf_done, bf_x, bf_y
    );

    modport slave (
        input  read_enable, write_enable,
        input  a_address, b_address, twiddle_address,
        input  a_write, b_write,
        output a_read, b_read, twiddle_read, ready,
        input  bf_valid, bf_a, bf_b, bf_w,
        output bf_ready, bf_done, bf_x, bf_y
    );

endinterface

// File: rtl/fft_stage_sequencer_addr_gen.sv
// Combinational in-place DIT address map: (stage s, butterfly k)
// to a/b data addresses and twiddle address, all modulo 2048.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int unsigned       LOG2N     = 10,
    parameter logic [ADDR_W-1:0] DATA_BASE = 11'd0,
    parameter logic [ADDR_W-1:0] TW_BASE   = 11'd1024
) (
    input  logic [3:0]        s,
    input  logic [9:0]        k,
    output logic [ADDR_W-1:0] a_address,
    output logic [ADDR_W-1:0] b_address,
    output logic [ADDR_W-1:0] twiddle_address
);

    logic [ADDR_W-1:0] k_w;
    logic [ADDR_W-1:0] half;
    logic [ADDR_W-1:0] pos;
    logic [ADDR_W-1:0] grp;
    logic [3:0]        tw_sh;

    // split k into group/position and place the butterfly pair
    always_comb begin
        k_w             = {1'b0, k};
        half            = 11'd1 << s;
        pos             = k_w & (half - 11'd1);
        grp             = k_w >> s;
        a_address       = DATA_BASE + (grp << (s + 4'd1)) + pos;
        b_address       = a_address + half;
        tw_sh           = 4'(LOG2N - 1) - s;
        twiddle_address = TW_BASE + (pos << tw_sh);
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIT FFT sequencer: read, butterfly, write back.
// Build option: FFT_STALL_COUNT_EN adds output stall_cycles.
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int unsigned       LOG2N     = 10,
    parameter logic [ADDR_W-1:0] DATA_BASE = 11'd0,
    parameter logic [ADDR_W-1:0] TW_BASE   = 11'd1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
`ifdef FFT_STALL_COUNT_EN
    output logic [31:0] stall_cycles,
`endif
    fft_stage_sequencer_if.master bus
);

    localparam logic [3:0] ST_IDLE     = IDLE;
    localparam logic [3:0] ST_RD       = RD;
    localparam logic [3:0] ST_RD_REL   = RD_REL;
    localparam logic [3:0] ST_BF_ISSUE = BF_ISSUE;
    localparam logic [3:0] ST_BF_WAIT  = BF_WAIT;
    localparam logic [3:0] ST_WR       = WR;
    localparam logic [3:0] ST_WR_REL   = WR_REL;
    localparam logic [3:0] ST_ADV      = ADV;
    localparam logic [3:0] ST_DONE     = DONE;

    localparam logic [9:0] K_LAST = 10'((1 << (LOG2N - 1)) - 1);
    localparam logic [3:0] S_LAST = 4'(LOG2N - 1);

    logic [3:0]        state;
    logic [3:0]        s;
    logic [9:0]        k;
    logic [WORD_W-1:0] op_a;
    logic [WORD_W-1:0] op_b;
    logic [WORD_W-1:0] op_w;
    logic [WORD_W-1:0] res_x;
    logic [WORD_W-1:0] res_y;
    logic [ADDR_W-1:0] a_gen;
    logic [ADDR_W-1:0] b_gen;
    logic [ADDR_W-1:0] tw_gen;

    fft_addr_gen #(
        .LOG2N     (LOG2N),
        .DATA_BASE (DATA_BASE),
        .TW_BASE   (TW_BASE)
    ) u_addr_gen (
        .s               (s),
        .k               (k),
        .a_address       (a_gen),
        .b_address       (b_gen),
        .twiddle_address (tw_gen)
    );

    assign busy = (state != ST_IDLE) && (state != ST_DONE);
    assign done = (state == ST_DONE);

    // addresses read as zero while idle, otherwise track (s, k)
    assign bus.a_address       = busy ? a_gen  : '0;
    assign bus.b_address       = busy ? b_gen  : '0;
    assign bus.twiddle_address = busy ? tw_gen : '0;

    assign bus.read_enable  = (state == ST_RD);
    assign bus.write_enable = (state == ST_WR);
    assign bus.a_write      = res_x;
    assign bus.b_write      = res_y;
    assign bus.bf_valid     = (state == ST_BF_ISSUE);
    assign bus.bf_a         = op_a;
    assign bus.bf_b         = op_b;
    assign bus.bf_w         = op_w;

    // stage/butterfly walk and handshake sequencing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            s     <= '0;
            k     <= '0;
            op_a  <= '0;
            op_b  <= '0;
            op_w  <= '0;
            res_x <= '0;
            res_y <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        s     <= '0;
                        k     <= '0;
                        state <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (bus.ready) begin
                        op_a  <= bus.a_read;
                        op_b  <= bus.b_read;
                        op_w  <= bus.twiddle_read;
                        state <= ST_RD_REL;
                    end
                end
                ST_RD_REL: state <= ST_BF_ISSUE;
                ST_BF_ISSUE: begin
                    if (bus.bf_ready && bus.bf_done) begin
                        res_x <= bus.bf_x;
                        res_y <= bus.bf_y;
                        state <= ST_WR;
                    end else if (bus.bf_ready) begin
                        state <= ST_BF_WAIT;
                    end
                end
                ST_BF_WAIT: begin
                    if (bus.bf_done) begin
                        res_x <= bus.bf_x;
                        res_y <= bus.bf_y;
                        state <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (bus.ready) state <= ST_WR_REL;
                end
                ST_WR_REL: state <= ST_ADV;
                ST_ADV: begin
                    if (k != K_LAST) begin
                        k     <= k + 10'd1;
                        state <= ST_RD;
                    end else if (s != S_LAST) begin
                        s     <= s + 4'd1;
                        k     <= '0;
                        state <= ST_RD;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FFT_STALL_COUNT_EN
    // saturating count of controller wait cycles in RD/WR
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (state == ST_IDLE && start) begin
            stall_cycles <= '0;
        end else if ((state == ST_RD || state == ST_WR) &&
                     !bus.ready && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
In-place radix-2 DIT FFT sequencer that sits directly upstream of the RAM controller. It walks every stage and every butterfly, and drives the controller's read and write handshakes with a/b/twiddle addresses. It hands each operand triple to an external butterfly unit, then writes the two results back to the same addresses. Input data must already be in bit-reversed order in RAM, and twiddles are pre-stored at TW_BASE.

Parameters:
LOG2N, 10, log2 of FFT length N; legal range 1..10.
DATA_BASE, 11'd0, word address of data point 0.
TW_BASE, 11'd1024, word address of twiddle W^0; twiddle table holds N/2 words.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; starts a full FFT when idle
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the final write is acknowledged
read_enable  out  1  to controller; request a three-word read
write_enable  out  1  to controller; request a two-word write
a_address  out  11  word address of butterfly input/output a
b_address  out  11  word address of butterfly input/output b
twiddle_address  out  11  twiddle word address
a_write  out  64  result x written to a_address
b_write  out  64  result y written to b_address
a_read  in  64  controller read data a; valid when ready
b_read  in  64  controller read data b; valid when ready
twiddle_read  in  64  controller read data w; valid when ready
ready  in  1  controller acknowledge (read or write complete)
bf_valid  out  1  operands valid to butterfly unit
bf_a  out  64  operand a
bf_b  out  64  operand b
bf_w  out  64  twiddle operand
bf_ready  in  1  butterfly accepts the operands when bf_valid && bf_ready
bf_done  in  1  bf_x and bf_y valid this cycle
bf_x  in  64  result a + w*b
bf_y  in  64  result a - w*b

Behaviour:
- Reset values: every output is 0, the state is IDLE, and the stage and butterfly counters are 0.
- State machine:
  - IDLE: on start, clear s and k and go to RD. start is ignored in every other state.
  - RD: read_enable=1. On ready, capture a_read, b_read and twiddle_read into the operand registers, then go to RD_REL.
  - RD_REL: read_enable=0 for exactly one cycle, then go to BF_ISSUE. This mandatory gap stops the controller from re-reading.
  - BF_ISSUE: bf_valid=1 with the operand registers driven on bf_a, bf_b and bf_w. When bf_ready is seen, go to BF_WAIT.
  - BF_WAIT: when bf_done is seen, capture bf_x into a_write and bf_y into b_write, then go to WR. A bf_done that arrives in the same cycle as acceptance is legal and is honoured.
  - WR: write_enable=1. On ready, go to WR_REL.
  - WR_REL: write_enable=0 for one cycle, then go to ADV.
  - ADV: if k < N/2-1, then k++ and go to RD. Otherwise, if s < LOG2N-1, then s++, k=0 and go to RD. Otherwise go to DONE.
  - DONE: done=1 for one cycle, busy=0, then go to IDLE.
- Address generation, from registered s and k:
  - half = 1<<s; pos = k & (half-1); grp = k >> s.
  - a_address = DATA_BASE + (grp << (s+1)) + pos.
  - b_address = a_address + half.
  - twiddle_address = TW_BASE + (pos << (LOG2N-1-s)).
  - All arithmetic is 11-bit unsigned and wraps modulo 2048.
  - Addresses are held stable from RD through WR_REL of the same butterfly.
- read_enable and write_enable are never high together.
- Latency per butterfly: read handshake + 1 + butterfly latency + write handshake + 3 cycles.
- A ready pulse outside RD or WR is ignored. A bf_done pulse outside BF_WAIT is ignored.
- Reset asserted mid-operation aborts immediately. Both enables drop asynchronously and RAM contents are left partially updated.
- Total butterflies = LOG2N * N/2.

Optional Feature:
FFT_STALL_COUNT_EN
- Defined: adds output stall_cycles [31:0]. It counts the cycles spent in RD or WR with ready=0, clears on an accepted start, saturates at 2^32-1, and holds its value after done.
- Undefined: the port and the counter do not exist.

Decomposition:
- Package fft_pkg holds:
  - sequencer state enum (IDLE, RD, RD_REL, BF_ISSUE, BF_WAIT, WR, WR_REL, ADV, DONE);
  - ADDR_W=11 and WORD_W=64 constants.
- One sub-module is natural: fft_addr_gen, purely combinational, mapping (s, k) to the three addresses. It is unit-testable on its own.

Test Plan:
- LOG2N=3, controller model with 2-cycle ready, start -> exactly 12 read/write pairs; stage0 k=0 gives a=0, b=1, tw=1024; done pulses once, busy falls the same cycle.
- LOG2N=3, stage1 k=1 -> a=1, b=3, tw=1026; stage2 k=3 -> a=3, b=7, tw=1027.
- Controller ready delayed 5 cycles, bf_ready low for 3 cycles -> read_enable/bf_valid held steady with stable addresses; each enable drops for exactly 1 cycle after ready.
- Butterfly returns bf_x=64'h1111, bf_y=64'h2222 -> the next write carries a_write=64'h1111, b_write=64'h2222 to the same a/b addresses that were read.
- Reset asserted during WR of stage 1 -> write_enable=0 immediately, busy=0; a following start restarts at s=0, k=0.
- FFT_STALL_COUNT_EN defined, ready latency fixed at 2 cycles, LOG2N=2 -> stall_cycles=16 at done; a second start clears it.
